// File: rtl/bit_population_counter_pkg.sv
// bit_population_counter_pkg: derives count width, latency and padded tree width from the input width
package bit_population_counter_pkg;
  function automatic int out_w(input int width);
    return $clog2(width) + 1;
  endfunction
  function automatic int lat(input int width);
    return $clog2(width) + 1;
  endfunction
  function automatic int pad_w(input int width);
    return 1 << $clog2(width);
  endfunction
endpackage

// File: rtl/bit_population_counter_adder_level.sv
// bit_population_counter_adder_level: one registered adder-tree level, pairs of W-bit operands into W+1-bit sums
module bit_population_counter_adder_level #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid,
  input  logic [N*W-1:0]           operands,
  output logic [(N/2)*(W+1)-1:0]   sums,
  output logic                     sum_valid
);
  localparam int S = W + 1;
  // sums only move with a valid word so the final level holds its last result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sums      <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= valid;
      if (valid)
        for (int i = 0; i < N / 2; i++)
          sums[i*S +: S] <= S'(operands[2*i*W +: W]) + S'(operands[(2*i+1)*W +: W]);
    end
endmodule

// File: rtl/bit_population_counter.sv
// bit_population_counter: fully pipelined popcount, input register followed by a registered binary adder tree
module bit_population_counter
  import bit_population_counter_pkg::*;
#(
  parameter int  WIDTH = 8,
  localparam int OUT_W = out_w(WIDTH),
  localparam int LAT   = lat(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  output logic [OUT_W-1:0] data_o,
  output logic             data_val_o
);
  localparam int P = pad_w(WIDTH);
  localparam int L = LAT - 1;
  for (genvar k = 0; k <= L; k++) begin : g
    logic [(P>>k)*(k+1)-1:0] ops;
    logic                    val;
    if (k == 0) begin : s
      // zero-extension to the padded width keeps padding bits out of the count
      always_ff @(posedge clk_i or negedge srst_i)
        if (!srst_i) begin
          ops <= '0;
          val <= 1'b0;
        end else begin
          val <= data_val_i;
          if (data_val_i) ops <= P'(data_i);
        end
    end else begin : s
      bit_population_counter_adder_level #(.N(P >> (k-1)), .W(k)) u_level (
        .clk      (clk_i),
        .rst_n    (srst_i),
        .valid    (g[k-1].val),
        .operands (g[k-1].ops),
        .sums     (ops),
        .sum_valid(val)
      );
    end
  end
  assign data_o     = g[L].ops;
  assign data_val_o = g[L].val;
endmodule

// File: tb/tb_bit_population_counter.sv
// tb_bit_population_counter: directed and random checks of the popcount pipeline at WIDTH 8, 5 and 1
module tb_bit_population_counter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d8 = '0;
  logic       v8 = 1'b0;
  logic [3:0] o8;
  logic       ov8;
  logic [4:0] d5 = '0;
  logic       v5 = 1'b0;
  logic [3:0] o5;
  logic       ov5;
  logic       d1 = 1'b0;
  logic       v1 = 1'b0;
  logic       o1;
  logic       ov1;
  int         vectors = 0;
  int         errs = 0;
  logic [7:0] q[$];
  logic [7:0] last;
  int         acc;

  always #5 clk = ~clk;

  bit_population_counter #(.WIDTH(8)) u8 (
    .clk_i(clk), .srst_i(rst_n), .data_i(d8), .data_val_i(v8), .data_o(o8), .data_val_o(ov8));
  bit_population_counter #(.WIDTH(5)) u5 (
    .clk_i(clk), .srst_i(rst_n), .data_i(d5), .data_val_i(v5), .data_o(o5), .data_val_o(ov5));
  bit_population_counter #(.WIDTH(1)) u1 (
    .clk_i(clk), .srst_i(rst_n), .data_i(d1), .data_val_i(v1), .data_o(o1), .data_val_o(ov1));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    tick(2);
    chk("rst_val8", 8'(ov8), 0);
    chk("rst_data8", 8'(o8), 0);
    chk("rst_val5", 8'(ov5), 0);
    chk("rst_val1", 8'(ov1), 0);
    rst_n = 1'b1;
    d8 = 8'h0F; v8 = 1'b1;
    tick;
    v8 = 1'b0;
    tick(2);
    rst_n = 1'b0;
    #1 chk("midrst_val", 8'(ov8), 0);
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("flushed_val", 8'(ov8), 0);
      chk("flushed_data", 8'(o8), 0);
    end
    d8 = 8'h00; v8 = 1'b1;
    tick;
    v8 = 1'b0;
    chk("lat_e1", 8'(ov8), 0);
    for (int i = 2; i <= 5; i++) begin
      tick;
      chk("lat_val", 8'(ov8), (i == 4) ? 8'd1 : 8'd0);
    end
    chk("zero_data", 8'(o8), 0);
    d8 = 8'hFF; v8 = 1'b1;
    tick;
    d8 = 8'hA5;
    tick;
    v8 = 1'b0;
    tick(2);
    chk("ff_val", 8'(ov8), 1);
    chk("ff_data", 8'(o8), 8);
    tick;
    chk("a5_val", 8'(ov8), 1);
    chk("a5_data", 8'(o8), 4);
    tick;
    chk("a5_after_val", 8'(ov8), 0);
    chk("a5_hold", 8'(o8), 4);
    d8 = 8'h01; v8 = 1'b1;
    tick;
    d8 = 8'h03;
    tick;
    d8 = 8'h07;
    tick;
    v8 = 1'b0;
    tick;
    chk("b2b1_val", 8'(ov8), 1);
    chk("b2b1_data", 8'(o8), 1);
    tick;
    chk("b2b2_val", 8'(ov8), 1);
    chk("b2b2_data", 8'(o8), 2);
    tick;
    chk("b2b3_val", 8'(ov8), 1);
    chk("b2b3_data", 8'(o8), 3);
    tick;
    chk("b2b_end_val", 8'(ov8), 0);
    chk("b2b_hold", 8'(o8), 3);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_data", 8'(o8), 0);
    tick;
    rst_n = 1'b1;
    d5 = 5'b11111; v5 = 1'b1;
    d1 = 1'b1; v1 = 1'b1;
    tick;
    chk("w1_val", 8'(ov1), 1);
    chk("w1_data", 8'(o1), 1);
    d5 = 5'b10001;
    d1 = 1'b0;
    tick;
    v5 = 1'b0; v1 = 1'b0;
    chk("w1_zero", 8'(o1), 0);
    chk("w5_early", 8'(ov5), 0);
    tick;
    chk("w1_bubble", 8'(ov1), 0);
    chk("w1_hold", 8'(o1), 0);
    tick;
    chk("w5_all_val", 8'(ov5), 1);
    chk("w5_all_data", 8'(o5), 5);
    tick;
    chk("w5_pad_val", 8'(ov5), 1);
    chk("w5_pad_data", 8'(o5), 2);
    last = 8'd0;
    acc = 0;
    while (acc < 1000) begin
      v8 = ($urandom_range(0, 2) != 0);
      d8 = 8'($urandom);
      tick;
      if (v8) begin
        q.push_back(8'($countones(d8)));
        acc++;
      end
      if (ov8) begin
        chk("rand_q_nonempty", 8'(q.size() != 0), 1);
        if (q.size() != 0) last = q.pop_front();
        chk("rand_data", 8'(o8), last);
      end else chk("rand_hold", 8'(o8), last);
    end
    v8 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (ov8) begin
        chk("drain_q_nonempty", 8'(q.size() != 0), 1);
        if (q.size() != 0) last = q.pop_front();
        chk("drain_data", 8'(o8), last);
      end
    end
    chk("drain_empty", 8'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
